lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store sequencer that sits directly upstream of the data-memory stage. It accepts one memory request at a time from EX over a valid/ready handshake. It checks alignment and one-hot encoding, drives the memory stage's combinational ports for a fixed access window, and returns a registered result to WB over a second valid/ready handshake. Stores are issued to memory for exactly one cycle per accepted request.

Parameters:
MEM_LATENCY, 1, cycles the memory ports are held per access (>=1); read data is sampled in the last cycle of the window
XLEN, 64, address/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  EX has a request
req_ready  out  1  block can accept a request (IDLE only)
req_addr  in  XLEN  effective address
req_ld_type  in  7  one-hot load type: [6]lb [5]lh [4]lw [3]ld [2]lbu [1]lhu [0]lwu
req_st_type  in  4  one-hot store type: [3]sb [2]sh [1]sw [0]sd
req_wdata  in  XLEN  store data, unshifted
req_rd  in  5  destination register tag
mem_raddr  out  XLEN  to memory stage read address
mem_ld_type  out  7  to memory stage; zero when not loading
mem_rdata  in  XLEN  formatted load data from memory stage
mem_waddr  out  XLEN  to memory stage write address
mem_wdata  out  XLEN  to memory stage write data
mem_st_type  out  4  to memory stage; zero except in the store issue cycle
resp_valid  out  1  result available
resp_ready  in  1  WB accepts the result
resp_rdata  out  XLEN  load result; 0 for stores, errors and no-ops
resp_rd  out  5  echoed req_rd
resp_addr  out  XLEN  echoed req_addr (used for trap value)
resp_misaligned  out  1  access not naturally aligned
resp_illegal  out  1  both ld_type and st_type nonzero, or either is multi-hot

Behaviour:
- Reset: all outputs 0, state IDLE, latency counter 0. req_ready is 0 during the reset cycle and rises the cycle after rst drops.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1 and all mem_* outputs are 0.
  - On req_valid&req_ready, latch addr, types, wdata and rd.
  - Classification happens in the acceptance cycle.
  - Illegal or misaligned: go to RESP with the matching flag set, rdata=0, and no memory activity.
  - Both type fields zero (no-op): go to RESP with rdata=0 and no flags.
  - Otherwise: go to ACCESS with counter=MEM_LATENCY-1.
- Alignment rules:
  - Byte: always aligned.
  - Half: addr[0]==0.
  - Word: addr[1:0]==0.
  - Double: addr[2:0]==0.
  - If a request is both illegal and misaligned, only resp_illegal is set.
- ACCESS:
  - mem_raddr=mem_waddr=latched addr and mem_wdata=latched wdata for every cycle of the window.
  - mem_ld_type=latched ld_type for every cycle of the window.
  - mem_st_type=latched st_type only in the first ACCESS cycle, 0 afterwards, so exactly one write occurs.
  - The counter decrements each cycle.
  - When counter==0: load mem_rdata into resp_rdata (loads only; 0 for stores) and go to RESP.
- RESP:
  - resp_valid=1; resp_* are stable and mem_* are 0.
  - On resp_ready, go to IDLE the next cycle.
  - resp_valid never drops without resp_ready.
- Latency: request accepted at edge T gives resp_valid at T+1+MEM_LATENCY. An error or no-op request gives resp_valid at T+1.
- Throughput: one request per (MEM_LATENCY+2) cycles. There is no bypass from RESP to accept a new request.
- Reset mid-ACCESS: abort, state IDLE, no response produced. A store whose issue cycle has already passed is not retracted.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Package lsu_pkg holds:
  - ld/st one-hot bit index constants (LB..LWU, SB..SD);
  - state enum {IDLE, ACCESS, RESP};
  - a function giving access size from the type fields.
- One natural sub-module, lsu_align_check: combinational. Inputs are addr[2:0], ld_type and st_type; outputs are misaligned, illegal and noop.
- The latency counter width is $clog2(MEM_LATENCY+1).

Test Plan:
- lw at 0x80000004, MEM_LATENCY=1, mem_rdata=0xFFFFFFFF87654321 -> mem_ld_type=7'b0010000 for 1 cycle; resp_valid 2 cycles after acceptance; resp_rdata=0xFFFFFFFF87654321; flags 0.
- sb at 0x80000003, wdata=0xAB -> mem_st_type=4'b1000 for exactly 1 cycle, waddr=0x80000003; resp_rdata=0; flags 0.
- lh at 0x80000001 -> no mem activity (mem_ld_type stays 0); resp_valid next cycle; resp_misaligned=1; resp_addr=0x80000001.
- ld, MEM_LATENCY=3, resp_ready held low 4 cycles -> resp_valid/resp_rdata stable throughout; req_ready stays 0 until the cycle after the resp handshake.
- ld_type=7'b0000011 -> resp_illegal=1, resp_misaligned=0, no memory access; a no-op request (both types 0) -> resp_valid with flags 0.
- sd accepted, rst asserted in the 2nd ACCESS cycle (MEM_LATENCY=3) -> exactly one write observed; no resp_valid; req_ready=1 in the cycle after rst drops.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: type bit positions,
// FSM states and the access-size decode used by the alignment checker.
package lsu_pkg;

  localparam int LB  = 6;
  localparam int LH  = 5;
  localparam int LW  = 4;
  localparam int LD  = 3;
  localparam int LBU = 2;
  localparam int LHU = 1;
  localparam int LWU = 0;

  localparam int SB = 3;
  localparam int SH = 2;
  localparam int SW = 1;
  localparam int SD = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Only meaningful for a one-hot request; other encodings are caught as illegal.
  function automatic size_e access_size(input logic [6:0] ld, input logic [3:0] st);
    size_e sz;
    if (ld[LH] || ld[LHU] || st[SH]) begin
      sz = SZ_H;
    end else if (ld[LW] || ld[LWU] || st[SW]) begin
      sz = SZ_W;
    end else if (ld[LD] || st[SD]) begin
      sz = SZ_D;
    end else begin
      sz = SZ_B;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational request classifier: encoding legality, no-op detection and
// natural-alignment check. Illegal requests never report misalignment.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [2:0] addr_lo,
  input  logic [6:0] ld_type,
  input  logic [3:0] st_type,
  output logic       misaligned,
  output logic       illegal,
  output logic       noop
);

  logic mis_raw;

  // Classify the request from its type fields and low address bits
  always_comb begin
    noop    = (ld_type == 7'd0) && (st_type == 4'd0);
    illegal = ((ld_type != 7'd0) && (st_type != 4'd0)) ||
              !$onehot0(ld_type) || !$onehot0(st_type);
    case (access_size(ld_type, st_type))
      SZ_H:    mis_raw = (addr_lo[0] != 1'b0);
      SZ_W:    mis_raw = (addr_lo[1:0] != 2'b00);
      SZ_D:    mis_raw = (addr_lo != 3'b000);
      default: mis_raw = 1'b0;
    endcase
    misaligned = mis_raw && !illegal && !noop;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EX and the data-memory stage: one request at a
// time, a fixed MEM_LATENCY access window, and a registered response to WB.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int XLEN        = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [6:0]      req_ld_type,
  input  logic [3:0]      req_st_type,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic [XLEN-1:0] mem_raddr,
  output logic [6:0]      mem_ld_type,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_waddr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_st_type,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_misaligned,
  output logic            resp_illegal
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [6:0]        mem_ld_type_q, mem_ld_type_d;
  logic [3:0]        mem_st_type_q, mem_st_type_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]   resp_addr_q, resp_addr_d;
  logic              resp_mis_q, resp_mis_d;
  logic              resp_ill_q, resp_ill_d;
  logic              chk_mis, chk_ill, chk_noop;

  lsu_align_check u_align (
    .addr_lo    (req_addr[2:0]),
    .ld_type    (req_ld_type),
    .st_type    (req_st_type),
    .misaligned (chk_mis),
    .illegal    (chk_ill),
    .noop       (chk_noop)
  );

  // Next-state and next-output logic; the mem_* registers double as the request latch
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_ld_type_d = mem_ld_type_q;
    mem_st_type_d = mem_st_type_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_rd_d     = resp_rd_q;
    resp_addr_d   = resp_addr_q;
    resp_mis_d    = resp_mis_q;
    resp_ill_d    = resp_ill_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d  = 1'b0;
          resp_rd_d    = req_rd;
          resp_addr_d  = req_addr;
          resp_mis_d   = chk_mis;
          resp_ill_d   = chk_ill;
          resp_rdata_d = '0;
          if (chk_ill || chk_mis || chk_noop) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d       = ACCESS;
            cnt_d         = CW'(MEM_LATENCY - 1);
            mem_addr_d    = req_addr;
            mem_wdata_d   = req_wdata;
            mem_ld_type_d = req_ld_type;
            mem_st_type_d = req_st_type;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ACCESS: begin
        mem_st_type_d = 4'd0;
        if (cnt_q == '0) begin
          state_d       = RESP;
          resp_valid_d  = 1'b1;
          resp_rdata_d  = (mem_ld_type_q != 7'd0) ? mem_rdata : '0;
          mem_addr_d    = '0;
          mem_wdata_d   = '0;
          mem_ld_type_d = 7'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d       = IDLE;
        req_ready_d   = 1'b0;
        resp_valid_d  = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_ld_type_d = 7'd0;
        mem_st_type_d = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_ld_type_q <= 7'd0;
      mem_st_type_q <= 4'd0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_rd_q     <= 5'd0;
      resp_addr_q   <= '0;
      resp_mis_q    <= 1'b0;
      resp_ill_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_ld_type_q <= mem_ld_type_d;
      mem_st_type_q <= mem_st_type_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_rd_q     <= resp_rd_d;
      resp_addr_q   <= resp_addr_d;
      resp_mis_q    <= resp_mis_d;
      resp_ill_q    <= resp_ill_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign mem_raddr       = mem_addr_q;
  assign mem_waddr       = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_ld_type     = mem_ld_type_q;
  assign mem_st_type     = mem_st_type_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_rd         = resp_rd_q;
  assign resp_addr       = resp_addr_q;
  assign resp_misaligned = resp_mis_q;
  assign resp_illegal    = resp_ill_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: two instances (MEM_LATENCY 1 and 3) sharing one stimulus
// path selected by sel, checked against a transaction-level reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, resp_ready;
  logic [63:0] req_addr, req_wdata, mem_rdata;
  logic [6:0]  req_ld_type;
  logic [3:0]  req_st_type;
  logic [4:0]  req_rd;

  logic        rr1, rr3, rv1, rv3, mis1, mis3, ill1, ill3;
  logic [63:0] mra1, mra3, mwa1, mwa3, mwd1, mwd3, rdt1, rdt3, radr1, radr3;
  logic [6:0]  mlt1, mlt3;
  logic [3:0]  mst1, mst3;
  logic [4:0]  rrd1, rrd3;

  logic        o_req_ready, o_resp_valid, o_mis, o_ill;
  logic [63:0] o_mem_raddr, o_mem_waddr, o_mem_wdata, o_resp_rdata, o_resp_addr;
  logic [6:0]  o_mem_ld_type;
  logic [3:0]  o_mem_st_type;
  logic [4:0]  o_resp_rd;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LATENCY(1), .XLEN(64)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr1),
    .req_addr(req_addr), .req_ld_type(req_ld_type), .req_st_type(req_st_type),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_raddr(mra1), .mem_ld_type(mlt1),
    .mem_rdata(mem_rdata), .mem_waddr(mwa1), .mem_wdata(mwd1), .mem_st_type(mst1),
    .resp_valid(rv1), .resp_ready(resp_ready & ~sel), .resp_rdata(rdt1), .resp_rd(rrd1),
    .resp_addr(radr1), .resp_misaligned(mis1), .resp_illegal(ill1)
  );

  lsu_ctrl #(.MEM_LATENCY(3), .XLEN(64)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
    .req_addr(req_addr), .req_ld_type(req_ld_type), .req_st_type(req_st_type),
    .req_wdata(req_wdata), .req_rd(req_rd), .mem_raddr(mra3), .mem_ld_type(mlt3),
    .mem_rdata(mem_rdata), .mem_waddr(mwa3), .mem_wdata(mwd3), .mem_st_type(mst3),
    .resp_valid(rv3), .resp_ready(resp_ready & sel), .resp_rdata(rdt3), .resp_rd(rrd3),
    .resp_addr(radr3), .resp_misaligned(mis3), .resp_illegal(ill3)
  );

  assign o_req_ready   = sel ? rr3   : rr1;
  assign o_resp_valid  = sel ? rv3   : rv1;
  assign o_mis         = sel ? mis3  : mis1;
  assign o_ill         = sel ? ill3  : ill1;
  assign o_mem_raddr   = sel ? mra3  : mra1;
  assign o_mem_waddr   = sel ? mwa3  : mwa1;
  assign o_mem_wdata   = sel ? mwd3  : mwd1;
  assign o_mem_ld_type = sel ? mlt3  : mlt1;
  assign o_mem_st_type = sel ? mst3  : mst1;
  assign o_resp_rdata  = sel ? rdt3  : rdt1;
  assign o_resp_addr   = sel ? radr3 : radr1;
  assign o_resp_rd     = sel ? rrd3  : rrd1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic int size_bytes(input logic [6:0] ld, input logic [3:0] st);
    if (ld[6] || ld[2] || st[3]) return 1;
    if (ld[5] || ld[1] || st[2]) return 2;
    if (ld[4] || ld[0] || st[1]) return 4;
    if (ld[3] || st[0])          return 8;
    return 1;
  endfunction

  task automatic do_req(input logic [6:0] ld, input logic [3:0] st, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [4:0] rd, input int stall);
    int  ml, guard, n, ld_cyc, st_cyc, exp_lat;
    bit  ill, noop, mis, acc, got_rv;
    logic [63:0] exp_rdata;
    ml   = sel ? 3 : 1;
    ill  = ((ld != 7'd0) && (st != 4'd0)) || ($countones(ld) > 1) || ($countones(st) > 1);
    noop = (ld == 7'd0) && (st == 4'd0);
    mis  = !ill && !noop && ((addr % 64'(size_bytes(ld, st))) != 64'd0);
    acc  = !ill && !noop && !mis;
    exp_lat   = acc ? ml + 1 : 1;
    exp_rdata = (acc && ld != 7'd0) ? rdata : 64'd0;

    guard = 0;
    @(negedge clk);
    while (!o_req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("req_ready_idle", {63'd0, o_req_ready}, 64'd1);
    check_eq("mem_idle", {53'd0, o_mem_ld_type, o_mem_st_type}, 64'd0);
    req_ld_type = ld; req_st_type = st; req_addr = addr; req_wdata = wdata; req_rd = rd;
    mem_rdata = {$urandom, $urandom};
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_addr    = {$urandom, $urandom};
    req_wdata   = {$urandom, $urandom};
    req_ld_type = 7'($urandom);
    req_st_type = 4'($urandom);
    req_rd      = 5'($urandom);

    n = 0; ld_cyc = 0; st_cyc = 0; got_rv = 1'b0;
    while (n < 12 && !got_rv) begin
      @(negedge clk);
      n++;
      if (o_resp_valid) begin
        got_rv = 1'b1;
      end else begin
        check_eq("req_ready_busy", {63'd0, o_req_ready}, 64'd0);
        if (o_mem_ld_type != 7'd0) begin
          ld_cyc++;
          check_eq("mem_ld_type", {57'd0, o_mem_ld_type}, {57'd0, ld});
          check_eq("mem_raddr", o_mem_raddr, addr);
        end
        if (o_mem_st_type != 4'd0) begin
          st_cyc++;
          check_eq("mem_st_type", {60'd0, o_mem_st_type}, {60'd0, st});
          check_eq("mem_waddr", o_mem_waddr, addr);
          check_eq("mem_wdata", o_mem_wdata, wdata);
        end
        mem_rdata = (n == ml) ? rdata : {$urandom, $urandom};
      end
    end
    check_eq("resp_latency", 64'(n), 64'(exp_lat));
    check_eq("ld_window", 64'(ld_cyc), (acc && ld != 7'd0) ? 64'(ml) : 64'd0);
    check_eq("st_issue", 64'(st_cyc), (acc && st != 4'd0) ? 64'd1 : 64'd0);
    check_eq("mem_quiet_resp", {53'd0, o_mem_ld_type, o_mem_st_type}, 64'd0);
    check_eq("resp_rdata", o_resp_rdata, exp_rdata);
    check_eq("resp_rd", {59'd0, o_resp_rd}, {59'd0, rd});
    check_eq("resp_addr", o_resp_addr, addr);
    check_eq("resp_flags", {62'd0, o_ill, o_mis}, {62'd0, ill, mis});

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {63'd0, o_resp_valid}, 64'd1);
      check_eq("stall_rdata", o_resp_rdata, exp_rdata);
      check_eq("stall_ready", {63'd0, o_req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_eq("post_hs_valid", {63'd0, o_resp_valid}, 64'd0);
    check_eq("post_hs_ready", {63'd0, o_req_ready}, 64'd1);
  endtask

  task automatic reset_mid_access();
    int wr;
    sel = 1'b1;
    wr  = 0;
    @(negedge clk);
    check_eq("rst_pre_ready", {63'd0, o_req_ready}, 64'd1);
    req_ld_type = 7'd0; req_st_type = 4'b0001; req_addr = 64'h8000_0010;
    req_wdata = 64'h1122_3344_5566_7788; req_rd = 5'd9;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (o_mem_st_type != 4'd0) wr++;
    @(negedge clk);
    if (o_mem_st_type != 4'd0) wr++;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_valid", {63'd0, o_resp_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, o_req_ready}, 64'd0);
    check_eq("rst_in_mem", {53'd0, o_mem_ld_type, o_mem_st_type}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (o_mem_st_type != 4'd0) wr++;
      check_eq("rst_no_resp", {63'd0, o_resp_valid}, 64'd0);
      check_eq("rst_ready_after", {63'd0, o_req_ready}, 64'd1);
    end
    check_eq("rst_writes", 64'(wr), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  ld;
    logic [3:0]  st;
    int          kind;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; req_ld_type = 7'd0; req_st_type = 4'd0;
    req_rd = 5'd0; mem_rdata = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", {62'd0, rr1, rr3}, 64'd0);
    check_eq("rst_valid", {62'd0, rv1, rv3}, 64'd0);
    check_eq("rst_mem", {42'd0, mlt1, mst1, mlt3, mst3}, 64'd0);
    check_eq("rst_resp", rdt1 | rdt3 | radr1 | radr3 | {54'd0, rrd1, rrd3}, 64'd0);
    check_eq("rst_flags", {60'd0, mis1, ill1, mis3, ill3}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {62'd0, rr1, rr3}, 64'd3);

    sel = 1'b0;
    do_req(7'b0010000, 4'd0, 64'h8000_0004, 64'd0, 64'hFFFF_FFFF_8765_4321, 5'd3, 0);
    do_req(7'd0, 4'b1000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0, 5'd4, 0);
    do_req(7'b0100000, 4'd0, 64'h8000_0001, 64'd0, 64'h5555, 5'd5, 0);
    sel = 1'b1;
    do_req(7'b0001000, 4'd0, 64'h8000_0008, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 5'd6, 4);
    do_req(7'b0000011, 4'd0, 64'h8000_0001, 64'd0, 64'h1234, 5'd7, 1);
    sel = 1'b0;
    do_req(7'd0, 4'd0, 64'h8000_0002, 64'd0, 64'h9999, 5'd8, 0);
    reset_mid_access();

    for (int i = 0; i < 80; i++) begin
      sel  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      ld = 7'd0;
      st = 4'd0;
      if (kind <= 3) begin
        ld = 7'(1 << $urandom_range(0, 6));
      end else if (kind <= 6) begin
        st = 4'(1 << $urandom_range(0, 3));
      end else if (kind == 8) begin
        ld = 7'($urandom);
        st = 4'($urandom);
      end else if (kind == 9) begin
        ld = 7'($urandom) | 7'b0000011;
      end
      do_req(ld, st, {32'h8000_0000, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             5'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
